// File: rtl/mem_channel_router_pkg.sv
// Shared types and width helpers for the memory channel router.
package common_pkg;

  // Per-channel sequencing states.
  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ISSUE = 2'd1,
    CH_WAIT  = 2'd2
  } chan_state_t;

  // Number of address bits consumed by an n-way interleave (0 when n == 1).
  function automatic int unsigned sel_bits(input int unsigned n);
    return $clog2(n);
  endfunction

  // Width of an index register for n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_channel_router_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter
  import common_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            req,
  input  logic                    en,
  output logic [N-1:0]            grant,
  output logic [idx_width(N)-1:0] grant_idx
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_k;
  logic          w_found;

  // Scan downward from ptr+N-1 to ptr so the last hit is the closest one at/after ptr.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = IW'((int'(r_ptr) + i) % N);
      if (req[w_k]) begin
        w_found = 1'b1;
        w_idx   = w_k;
      end
    end
  end

  assign grant     = (en && w_found) ? (N'(1) << w_idx) : '0;
  assign grant_idx = w_idx;

  // Pointer moves past the winner only when a grant is actually issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_channel_router.sv
// Routes user requests onto line-interleaved memory channels, one
// arbiter + issue/wait sequencer per channel, responses back to the owner.
module mem_channel_router
  import common_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_USERS    = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int LINE_BYTES   = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_USERS-1:0]                   req_valid,
  output logic [NUM_USERS-1:0]                   req_ready,
  input  logic [NUM_USERS-1:0]                   req_we,
  input  logic [NUM_USERS-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_USERS-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_USERS-1:0]                   req_resp_valid,
  output logic [NUM_USERS-1:0][DATA_WIDTH-1:0]   req_resp_data,
  output logic [NUM_CHANNELS-1:0]                mem_valid,
  input  logic [NUM_CHANNELS-1:0]                mem_ready,
  output logic [NUM_CHANNELS-1:0]                mem_we,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_addr,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_data,
  input  logic [NUM_CHANNELS-1:0]                mem_resp_valid,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_resp_data
);

  localparam int OFF = sel_bits(LINE_BYTES);
  localparam int CB  = sel_bits(NUM_CHANNELS);
  localparam int CW  = idx_width(NUM_CHANNELS);
  localparam int UW  = idx_width(NUM_USERS);

  logic [CW-1:0]        w_chan     [NUM_USERS];
  logic [NUM_USERS-1:0] w_grant_ch [NUM_CHANNELS];
  logic                 w_done     [NUM_CHANNELS];
  logic [UW-1:0]        w_owner    [NUM_CHANNELS];

  logic [NUM_USERS-1:0]                 w_resp_v;
  logic [NUM_USERS-1:0][DATA_WIDTH-1:0] w_resp_d;
  logic [NUM_USERS-1:0]                 r_resp_v;
  logic [NUM_USERS-1:0][DATA_WIDTH-1:0] r_resp_d;

  for (genvar u = 0; u < NUM_USERS; u++) begin : g_sel
    if (NUM_CHANNELS == 1) begin : g_one
      assign w_chan[u] = '0;
    end else begin : g_many
      assign w_chan[u] = req_addr[u][OFF +: CB];
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    chan_state_t          r_state;
    logic [UW-1:0]        r_owner;
    logic                 r_valid;
    logic                 r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NUM_USERS-1:0] w_req;
    logic [NUM_USERS-1:0] w_grant;
    logic [UW-1:0]        w_gidx;
    logic                 w_en;

    // Candidates: valid users whose address interleaves onto this channel.
    always_comb begin
      w_req = '0;
      for (int u = 0; u < NUM_USERS; u++) begin
        w_req[u] = req_valid[u] && (w_chan[u] == CW'(c));
      end
    end

    // Arbitration only happens in IDLE and never while reset is held.
    assign w_en = reset && (r_state == CH_IDLE);

    rr_arbiter #(.N(NUM_USERS)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (w_req),
      .en        (w_en),
      .grant     (w_grant),
      .grant_idx (w_gidx)
    );

    // Channel sequencer: latch grant, present to memory, wait for completion.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state <= CH_IDLE;
        r_owner <= '0;
        r_valid <= 1'b0;
        r_we    <= 1'b0;
        r_addr  <= '0;
        r_data  <= '0;
      end else begin
        case (r_state)
          CH_IDLE: begin
            if (|w_grant) begin
              r_state <= CH_ISSUE;
              r_owner <= w_gidx;
              r_valid <= 1'b1;
              r_we    <= req_we[w_gidx];
              r_addr  <= req_addr[w_gidx];
              r_data  <= req_data[w_gidx];
            end
          end
          CH_ISSUE: begin
            if (mem_ready[c]) begin
              r_state <= CH_WAIT;
              r_valid <= 1'b0;
            end
          end
          CH_WAIT: begin
            if (mem_resp_valid[c]) r_state <= CH_IDLE;
          end
          default: r_state <= CH_IDLE;
        endcase
      end
    end

    assign mem_valid[c]  = r_valid;
    assign mem_we[c]     = r_we;
    assign mem_addr[c]   = r_addr;
    assign mem_data[c]   = r_data;
    assign w_grant_ch[c] = w_grant;
    assign w_done[c]     = (r_state == CH_WAIT) && mem_resp_valid[c];
    assign w_owner[c]    = r_owner;
  end

  // A user is served by at most one channel, so ready is a plain OR of grants.
  always_comb begin
    req_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      req_ready = req_ready | w_grant_ch[c];
    end
  end

  // Steer each channel completion to its owner; ownership is unique so OR suffices.
  always_comb begin
    w_resp_v = '0;
    w_resp_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int u = 0; u < NUM_USERS; u++) begin
        if (w_done[c] && (w_owner[c] == UW'(u))) begin
          w_resp_v[u] = 1'b1;
          w_resp_d[u] = w_resp_d[u] | mem_resp_data[c];
        end
      end
    end
  end

  // Register the completion pulse and data towards the users.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_resp_v <= '0;
      r_resp_d <= '0;
    end else begin
      r_resp_v <= w_resp_v;
      r_resp_d <= w_resp_d;
    end
  end

  assign req_resp_valid = r_resp_v;
  assign req_resp_data  = r_resp_d;

endmodule
